// File: rtl/accel_job_sequencer_if.sv
// Host, accelerator and memory-side signals of the job sequencer, bundled as one port.
// The master modport is the environment side; slave is the sequencer itself.
interface accel_job_sequencer_if;
  // host launch and status
  logic        start;
  logic [7:0]  job_count;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  jobs_done;

  // accelerator control and job-relative addressing
  logic        acc_comp_enb;
  logic        acc_done;
  logic [15:0] acc_mem_addr;
  logic [15:0] acc_res_addr;
  logic        acc_mem_write_enb;

  // translated memory side
  logic [15:0] mem_addr;
  logic [15:0] res_addr;
  logic        mem_write_enb;

  modport master (
    output start, job_count, base_addr,
    output acc_done, acc_mem_addr, acc_res_addr, acc_mem_write_enb,
    input  acc_comp_enb, mem_addr, res_addr, mem_write_enb,
    input  busy, done, error, jobs_done
  );

  modport slave (
    input  start, job_count, base_addr,
    input  acc_done, acc_mem_addr, acc_res_addr, acc_mem_write_enb,
    output acc_comp_enb, mem_addr, res_addr, mem_write_enb,
    output busy, done, error, jobs_done
  );
endinterface

// File: rtl/accel_job_sequencer.sv
// Runs a batch of accelerator jobs back to back, relocating each job's addresses
// by a per-job base and guarding every run phase with a watchdog.
module accel_job_sequencer #(
  parameter int unsigned JOB_STRIDE = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  accel_job_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_NEXT,
    S_ERR
  } state_e;

  localparam logic [15:0] STRIDE  = 16'(JOB_STRIDE);
  localparam logic [7:0]  WD_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] job_base_q, job_base_d;
  logic [7:0]  jobs_done_q, jobs_done_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        arm_q, arm_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  idx_inc;

  assign idx_inc = idx_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 8'd0;
      idx_q       <= 8'd0;
      job_base_q  <= 16'd0;
      jobs_done_q <= 8'd0;
      wdog_q      <= 8'd0;
      arm_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      job_base_q  <= job_base_d;
      jobs_done_q <= jobs_done_d;
      wdog_q      <= wdog_d;
      arm_q       <= arm_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    job_base_d  = job_base_q;
    jobs_done_d = jobs_done_q;
    wdog_d      = wdog_q;
    arm_d       = arm_q;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          jobs_done_d = 8'd0;
          error_d     = 1'b0;
          // An empty batch completes immediately without ever touching the accelerator.
          if (bus.job_count != 8'd0) begin
            state_d    = S_ARM;
            count_d    = bus.job_count;
            job_base_d = bus.base_addr;
            idx_d      = 8'd0;
            arm_d      = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_ARM: begin
        arm_d = 1'b1;
        if (arm_q) begin
          state_d = S_RUN;
          arm_d   = 1'b0;
          wdog_d  = 8'd0;
        end
      end

      S_RUN: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.acc_done) begin
          state_d = S_NEXT;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end

      S_NEXT: begin
        jobs_done_d = jobs_done_q + 8'd1;
        idx_d       = idx_inc;
        job_base_d  = job_base_q + STRIDE;
        if (idx_inc == count_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ARM;
          arm_d   = 1'b0;
        end
      end

      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Accelerator control and write gating come straight from the state register.
  assign bus.acc_comp_enb  = (state_q != S_RUN);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_write_enb = (state_q == S_RUN) ? bus.acc_mem_write_enb : 1'b1;

  assign bus.mem_addr  = bus.acc_mem_addr + job_base_q;
  assign bus.res_addr  = bus.acc_res_addr + job_base_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.jobs_done = jobs_done_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Directed bench for accel_job_sequencer: batches, empty batch, watchdog, reset abort,
// address wrap and ignored mid-batch starts, each with hand-computed expectations.
module tb_accel_job_sequencer;

  logic clk;
  logic rst;
  accel_job_sequencer_if bus ();

  accel_job_sequencer #(.JOB_STRIDE(3), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int fails;
  int done_pulses;
  int write_cycles;
  bit accel_en;
  int run_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator model: raises acc_done 5 cycles after comp_enb drops.
  always @(negedge clk) begin
    if (!accel_en || bus.acc_comp_enb) begin
      run_cnt      = 0;
      bus.acc_done = 1'b0;
    end else begin
      run_cnt = run_cnt + 1;
      if (run_cnt >= 5) bus.acc_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_pulses = done_pulses + 1;
    if (bus.mem_write_enb === 1'b0) write_cycles = write_cycles + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_comp(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.acc_comp_enb === level) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic launch(input logic [7:0] cnt, input logic [15:0] base);
    bus.start     = 1'b1;
    bus.job_count = cnt;
    bus.base_addr = base;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.job_count = 8'd0;
    bus.base_addr = 16'd0;
    bus.acc_mem_addr = 16'h1234;
    bus.acc_res_addr = 16'h0042;
    bus.acc_mem_write_enb = 1'b0;
    accel_en = 1'b0;
    tick(2);
    rst = 1'b0;
    checks++; if (bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL reset_comp_enb: got %b, expected 1", bus.acc_comp_enb); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b, expected 0", bus.error); end
    checks++; if (bus.jobs_done !== 8'd0) begin fails++; $display("FAIL reset_jobs_done: got %0d, expected 0", bus.jobs_done); end
    checks++; if (bus.mem_write_enb !== 1'b1) begin fails++; $display("FAIL reset_wr_gate: got %b, expected 1", bus.mem_write_enb); end
    checks++; if (bus.mem_addr !== 16'h1234) begin fails++; $display("FAIL reset_mem_addr: got %h, expected 1234", bus.mem_addr); end
    checks++; if (bus.res_addr !== 16'h0042) begin fails++; $display("FAIL reset_res_addr: got %h, expected 0042", bus.res_addr); end
    // reset wins over a simultaneous start
    rst = 1'b1;
    bus.start = 1'b1;
    bus.job_count = 8'd1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_over_start: busy got %b, expected 0", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL rst_over_start_after: busy %b comp_enb %b, expected 0 1", bus.busy, bus.acc_comp_enb); end
    $display("test_reset done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_two_jobs();
    bit ok;
    int pulses0;
    pulses0 = done_pulses;
    accel_en = 1'b1;
    bus.acc_mem_addr = 16'h0000;
    bus.acc_res_addr = 16'h0002;
    bus.acc_mem_write_enb = 1'b0;
    launch(8'd2, 16'h0100);
    checks++; if (bus.busy !== 1'b1 || bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL arm_first: busy %b comp_enb %b, expected 1 1", bus.busy, bus.acc_comp_enb); end
    checks++; if (bus.mem_write_enb !== 1'b1) begin fails++; $display("FAIL arm_wr_gate: got %b, expected 1", bus.mem_write_enb); end
    tick();
    checks++; if (bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL arm_second: comp_enb got %b, expected 1", bus.acc_comp_enb); end
    tick();
    checks++; if (bus.acc_comp_enb !== 1'b0) begin fails++; $display("FAIL start_latency: comp_enb got %b, expected 0", bus.acc_comp_enb); end
    checks++; if (bus.mem_addr !== 16'h0100) begin fails++; $display("FAIL job0_mem_addr: got %h, expected 0100", bus.mem_addr); end
    checks++; if (bus.res_addr !== 16'h0102) begin fails++; $display("FAIL job0_res_addr: got %h, expected 0102", bus.res_addr); end
    checks++; if (bus.mem_write_enb !== 1'b0) begin fails++; $display("FAIL run_wr_pass: got %b, expected 0", bus.mem_write_enb); end
    wait_comp(1'b1, 30, ok);
    checks++; if (!ok) begin fails++; $display("FAIL job0_end: comp_enb never rose, expected rise"); end
    wait_comp(1'b0, 30, ok);
    checks++; if (!ok) begin fails++; $display("FAIL job1_start: comp_enb never fell, expected fall"); end
    checks++; if (bus.mem_addr !== 16'h0103) begin fails++; $display("FAIL job1_mem_addr: got %h, expected 0103", bus.mem_addr); end
    checks++; if (bus.res_addr !== 16'h0105) begin fails++; $display("FAIL job1_res_addr: got %h, expected 0105", bus.res_addr); end
    checks++; if (bus.jobs_done !== 8'd1) begin fails++; $display("FAIL job1_jobs_done: got %0d, expected 1", bus.jobs_done); end
    wait_done(40, ok);
    checks++; if (!ok) begin fails++; $display("FAIL batch_done: done never pulsed, expected pulse"); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_with_done: got %b, expected 0", bus.busy); end
    checks++; if (bus.jobs_done !== 8'd2) begin fails++; $display("FAIL batch_jobs_done: got %0d, expected 2", bus.jobs_done); end
    tick();
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_width: got %b, expected 0", bus.done); end
    tick(3);
    checks++; if (done_pulses - pulses0 !== 1) begin fails++; $display("FAIL done_count: got %0d, expected 1", done_pulses - pulses0); end
    $display("test_two_jobs done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_zero_count();
    launch(8'd0, 16'h0500);
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b, expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL zero_idle: busy %b comp_enb %b, expected 0 1", bus.busy, bus.acc_comp_enb); end
    checks++; if (bus.jobs_done !== 8'd0) begin fails++; $display("FAIL zero_jobs_done: got %0d, expected 0", bus.jobs_done); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL zero_after: done %b busy %b comp_enb %b, expected 0 0 1", bus.done, bus.busy, bus.acc_comp_enb); end
    $display("test_zero_count done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    int pulses0;
    pulses0 = done_pulses;
    accel_en = 1'b0;
    launch(8'd1, 16'h0200);
    wait_comp(1'b0, 10, ok);
    checks++; if (!ok) begin fails++; $display("FAIL wd_run_entry: comp_enb never fell, expected fall"); end
    n = 0;
    while (bus.acc_comp_enb === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 16) begin fails++; $display("FAIL wd_run_cycles: got %0d, expected 16", n); end
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wd_err_busy: got %b, expected 1", bus.busy); end
    tick();
    checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL wd_error: error %b busy %b, expected 1 0", bus.error, bus.busy); end
    checks++; if (bus.jobs_done !== 8'd0 || bus.acc_comp_enb !== 1'b1) begin fails++; $display("FAIL wd_state: jobs_done %0d comp_enb %b, expected 0 1", bus.jobs_done, bus.acc_comp_enb); end
    tick(4);
    checks++; if (bus.error !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b, expected 1", bus.error); end
    checks++; if (done_pulses - pulses0 !== 0) begin fails++; $display("FAIL wd_no_done: got %0d pulses, expected 0", done_pulses - pulses0); end
    $display("test_timeout done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_rst_mid_run();
    bit ok;
    int pulses0;
    int writes0;
    pulses0 = done_pulses;
    accel_en = 1'b1;
    bus.acc_mem_addr = 16'h0010;
    bus.acc_mem_write_enb = 1'b0;
    launch(8'd3, 16'h0300);
    checks++; if (bus.error !== 1'b0) begin fails++; $display("FAIL start_clears_error: got %b, expected 0", bus.error); end
    wait_comp(1'b0, 10, ok);
    wait_comp(1'b1, 30, ok);
    wait_comp(1'b0, 30, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rst_job1_entry: comp_enb never fell, expected fall"); end
    tick(2);
    checks++; if (bus.jobs_done !== 8'd1 || bus.mem_write_enb !== 1'b0) begin fails++; $display("FAIL rst_pre: jobs_done %0d wr %b, expected 1 0", bus.jobs_done, bus.mem_write_enb); end
    checks++; if (bus.mem_addr !== 16'h0313) begin fails++; $display("FAIL rst_pre_addr: got %h, expected 0313", bus.mem_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.acc_comp_enb !== 1'b1 || bus.mem_write_enb !== 1'b1) begin fails++; $display("FAIL rst_abort_ctrl: busy %b comp_enb %b wr %b, expected 0 1 1", bus.busy, bus.acc_comp_enb, bus.mem_write_enb); end
    checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0 || bus.jobs_done !== 8'd0) begin fails++; $display("FAIL rst_abort_status: done %b error %b jobs_done %0d, expected 0 0 0", bus.done, bus.error, bus.jobs_done); end
    checks++; if (bus.mem_addr !== 16'h0010) begin fails++; $display("FAIL rst_abort_base: mem_addr got %h, expected 0010", bus.mem_addr); end
    writes0 = write_cycles;
    tick(10);
    checks++; if (write_cycles - writes0 !== 0 || done_pulses - pulses0 !== 0) begin fails++; $display("FAIL rst_quiet: writes %0d done %0d, expected 0 0", write_cycles - writes0, done_pulses - pulses0); end
    $display("test_rst_mid_run done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_wrap();
    bit ok;
    bus.acc_mem_addr = 16'h0000;
    bus.acc_res_addr = 16'h0002;
    launch(8'd2, 16'hFFFE);
    wait_comp(1'b0, 10, ok);
    checks++; if (bus.mem_addr !== 16'hFFFE || bus.res_addr !== 16'h0000) begin fails++; $display("FAIL wrap_job0: mem %h res %h, expected fffe 0000", bus.mem_addr, bus.res_addr); end
    wait_comp(1'b1, 30, ok);
    wait_comp(1'b0, 30, ok);
    checks++; if (bus.mem_addr !== 16'h0001) begin fails++; $display("FAIL wrap_job1_base: got %h, expected 0001", bus.mem_addr); end
    checks++; if (bus.res_addr !== 16'h0003) begin fails++; $display("FAIL wrap_job1_res: got %h, expected 0003", bus.res_addr); end
    wait_done(40, ok);
    checks++; if (!ok || bus.jobs_done !== 8'd2) begin fails++; $display("FAIL wrap_done: seen %b jobs_done %0d, expected 1 2", ok, bus.jobs_done); end
    tick();
    $display("test_wrap done: checks=%0d failures=%0d", checks, fails);
  endtask

  task automatic test_start_ignored();
    bit ok;
    int pulses0;
    pulses0 = done_pulses;
    bus.acc_mem_addr = 16'h0000;
    launch(8'd2, 16'h0400);
    wait_comp(1'b0, 10, ok);
    bus.start = 1'b1;
    bus.job_count = 8'd5;
    bus.base_addr = 16'h9000;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.mem_addr !== 16'h0400 || bus.acc_comp_enb !== 1'b0) begin fails++; $display("FAIL ign_run: mem %h comp_enb %b, expected 0400 0", bus.mem_addr, bus.acc_comp_enb); end
    wait_comp(1'b1, 30, ok);
    wait_comp(1'b0, 30, ok);
    checks++; if (bus.mem_addr !== 16'h0403) begin fails++; $display("FAIL ign_job1: got %h, expected 0403", bus.mem_addr); end
    wait_done(40, ok);
    checks++; if (!ok || bus.jobs_done !== 8'd2) begin fails++; $display("FAIL ign_done: seen %b jobs_done %0d, expected 1 2", ok, bus.jobs_done); end
    tick(6);
    checks++; if (bus.busy !== 1'b0 || done_pulses - pulses0 !== 1) begin fails++; $display("FAIL ign_after: busy %b pulses %0d, expected 0 1", bus.busy, done_pulses - pulses0); end
    $display("test_start_ignored done: checks=%0d failures=%0d", checks, fails);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    done_pulses = 0;
    write_cycles = 0;
    accel_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.job_count = 8'd0;
    bus.base_addr = 16'd0;
    bus.acc_mem_addr = 16'd0;
    bus.acc_res_addr = 16'd0;
    bus.acc_mem_write_enb = 1'b1;
    test_reset();
    test_two_jobs();
    test_zero_count();
    test_timeout();
    test_rst_mid_run();
    test_wrap();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
